// File: rtl/i2s_speaker_ctl_pkg.sv
// Shared constants for the I2S speaker controller: counter width and the
// counter bit positions that the derived audio clocks are tapped from.
package i2s_speaker_ctl_pkg;

    localparam int CNT_W    = 10;
    localparam int MCLK_BIT = 1;
    localparam int SCK_BIT  = 3;
    localparam int LRCK_BIT = 9;
    localparam int SLOT_HI  = 8;
    localparam int SLOT_LO  = 4;
    localparam int SLOT_W   = SLOT_HI - SLOT_LO + 1;

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [SLOT_W-1:0] slot_t;

    localparam cnt_t CNT_LAST = '1;

    function automatic slot_t slot_of(input cnt_t c);
        return c[SLOT_HI:SLOT_LO];
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Free-running frame counter; MCLK, SCK and LRCK are taken directly from
// counter flop bits so they carry no combinational glitches.
module i2s_clk_gen
    import i2s_speaker_ctl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output cnt_t o_cnt,
    output cnt_t o_cnt_nxt,
    output logic o_mclk,
    output logic o_sck,
    output logic o_lrck
);

    cnt_t r_cnt;
    cnt_t w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_cnt_nxt = w_cnt_nxt;
    assign o_mclk    = r_cnt[MCLK_BIT];
    assign o_sck     = r_cnt[SCK_BIT];
    assign o_lrck    = r_cnt[LRCK_BIT];

endmodule

// File: rtl/i2s_speaker_ctl.sv
// I2S serializer for the Pmod I2S DAC: latches a stereo pair once per
// 1024-clk frame and shifts it out MSB first, one SCK after each LRCK edge.
module i2s_speaker_ctl
    import i2s_speaker_ctl_pkg::*;
#(
    parameter int DW = 16
)(
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] audio_left,
    input  logic [DW-1:0] audio_right,
    output logic          audio_mclk,
    output logic          audio_lrck,
    output logic          audio_sck,
    output logic          audio_sdin,
    output logic          sample_tick
);

    cnt_t          w_cnt;
    cnt_t          w_cnt_nxt;
    logic          w_cap;
    logic [DW-1:0] r_lat_l;
    logic [DW-1:0] r_lat_r;
    logic [DW-1:0] w_lat_l_nxt;
    logic [DW-1:0] w_lat_r_nxt;
    logic [DW-1:0] w_lat_sel;
    logic [31:0]   w_word;
    slot_t         w_slot;
    logic          w_sdin_nxt;
    logic          r_sdin;
    logic          r_tick;

    i2s_clk_gen u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .o_cnt     (w_cnt),
        .o_cnt_nxt (w_cnt_nxt),
        .o_mclk    (audio_mclk),
        .o_sck     (audio_sck),
        .o_lrck    (audio_lrck)
    );

    assign w_cap       = (w_cnt == CNT_LAST);
    assign w_lat_l_nxt = w_cap ? audio_left  : r_lat_l;
    assign w_lat_r_nxt = w_cap ? audio_right : r_lat_r;

    // sdin is registered from the next counter value, so it moves on the
    // SCK falling edge and slot 0 right after wrap already sees the new pair.
    assign w_lat_sel = w_cnt_nxt[LRCK_BIT] ? w_lat_r_nxt : w_lat_l_nxt;
    assign w_slot    = slot_of(w_cnt_nxt);

    // Word image indexed by slot: bit 31 is slot 0 (always 0), MSB sits at
    // bit 30, and slots past the sample width fall into zero fill.
    assign w_word     = 32'({1'b0, w_lat_sel}) << (31 - DW);
    assign w_sdin_nxt = w_word[5'd31 - w_slot];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lat_l <= '0;
            r_lat_r <= '0;
            r_sdin  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_lat_l <= w_lat_l_nxt;
            r_lat_r <= w_lat_r_nxt;
            r_sdin  <= w_sdin_nxt;
            r_tick  <= (w_cnt_nxt == CNT_LAST);
        end
    end

    assign audio_sdin  = r_sdin;
    assign sample_tick = r_tick;

endmodule

// File: tb/tb_i2s_speaker_ctl.sv
// Directed bench for i2s_speaker_ctl: clock ratios, frame data, capture
// isolation, SCK/SDIN edge alignment and mid-frame reset.
module tb_i2s_speaker_ctl;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] audio_left  = '0;
    logic [DW-1:0] audio_right = '0;
    logic          audio_mclk;
    logic          audio_lrck;
    logic          audio_sck;
    logic          audio_sdin;
    logic          sample_tick;

    i2s_speaker_ctl #(.DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .audio_mclk  (audio_mclk),
        .audio_lrck  (audio_lrck),
        .audio_sck   (audio_sck),
        .audio_sdin  (audio_sdin),
        .sample_tick (sample_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame position, advanced once per clk after reset release.
    logic [9:0]  m_cnt;
    logic [31:0] cap_l, cap_r;
    logic        prev_sdin;
    int          tick_cnt;
    int          cyc_rel;
    int          first_mclk, first_sck, first_lrck;
    logic        p_mclk, p_sck, p_lrck;
    int          rise_mclk, rise_sck, rise_lrck;
    int          high_mclk, high_sck, high_lrck;

    task automatic tick();
        @(posedge clk);
        m_cnt = m_cnt + 10'd1;
        cyc_rel++;
        #1;
        chk("mclk", 32'(audio_mclk), 32'(m_cnt[1]));
        chk("sck", 32'(audio_sck), 32'(m_cnt[3]));
        chk("lrck", 32'(audio_lrck), 32'(m_cnt[9]));
        chk("sample_tick", 32'(sample_tick), 32'(m_cnt == 10'd1023));
        if (sample_tick) tick_cnt++;
        if (audio_sdin !== prev_sdin) begin
            chk("sdin_edge_sck", 32'(audio_sck), 32'd0);
            chk("sdin_edge_phase", 32'(m_cnt[3:0]), 32'd0);
        end
        prev_sdin = audio_sdin;
        if (m_cnt[3:0] == 4'd8) begin
            if (m_cnt[9]) cap_r[5'd31 - m_cnt[8:4]] = audio_sdin;
            else          cap_l[5'd31 - m_cnt[8:4]] = audio_sdin;
        end
        if (first_mclk < 0 && audio_mclk) first_mclk = cyc_rel;
        if (first_sck  < 0 && audio_sck)  first_sck  = cyc_rel;
        if (first_lrck < 0 && audio_lrck) first_lrck = cyc_rel;
        if (audio_mclk && !p_mclk) rise_mclk++;
        if (audio_sck  && !p_sck)  rise_sck++;
        if (audio_lrck && !p_lrck) rise_lrck++;
        if (audio_mclk) high_mclk++;
        if (audio_sck)  high_sck++;
        if (audio_lrck) high_lrck++;
        p_mclk = audio_mclk;
        p_sck  = audio_sck;
        p_lrck = audio_lrck;
    endtask

    // One full frame starting at m_cnt==0; optionally changes the left input
    // at a given position inside the frame.
    task automatic run_frame(input string name, input logic [31:0] exp_l, input logic [31:0] exp_r,
                             input int chg_at, input logic [DW-1:0] chg_val);
        tick_cnt = 0;
        cap_l = 32'hDEAD_BEEF;
        cap_r = 32'hDEAD_BEEF;
        for (int i = 0; i < 1024; i++) begin
            tick();
            if (int'(m_cnt) == chg_at) audio_left = chg_val;
        end
        chk({name, "_left"}, cap_l, exp_l);
        chk({name, "_right"}, cap_r, exp_r);
        chk({name, "_ticks"}, 32'(tick_cnt), 32'd1);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_mclk"}, 32'(audio_mclk), 32'd0);
        chk({name, "_lrck"}, 32'(audio_lrck), 32'd0);
        chk({name, "_sck"}, 32'(audio_sck), 32'd0);
        chk({name, "_sdin"}, 32'(audio_sdin), 32'd0);
        chk({name, "_tick"}, 32'(sample_tick), 32'd0);
    endtask

    typedef struct {
        logic [DW-1:0] left;
        logic [DW-1:0] right;
        logic [31:0]   exp_l;
        logic [31:0]   exp_r;
    } vec_t;

    vec_t vecs[4];

    initial begin
        // Expected words: bit 31 = slot 0, bit 30 = slot 1 (MSB), ...
        vecs[0] = '{16'hB000, 16'h5FFF, 32'h5800_0000, 32'h2FFF_8000};
        vecs[1] = '{16'hFFFF, 16'h8001, 32'h7FFF_8000, 32'h4000_8000};
        vecs[2] = '{16'h0000, 16'hFFFF, 32'h0000_0000, 32'h7FFF_8000};
        vecs[3] = '{16'h1234, 16'h0001, 32'h091A_0000, 32'h0000_8000};

        m_cnt = '0; prev_sdin = 1'b0; cyc_rel = 0;
        first_mclk = -1; first_sck = -1; first_lrck = -1;
        p_mclk = 0; p_sck = 0; p_lrck = 0;
        rise_mclk = 0; rise_sck = 0; rise_lrck = 0;
        high_mclk = 0; high_sck = 0; high_lrck = 0;

        // Reset held for 20 clk with changing inputs: everything stays 0.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            audio_left  = 16'(i * 16'h1111);
            audio_right = ~audio_left;
            if (i % 4 == 3) chk_outputs_zero("reset_hold");
        end

        audio_left  = vecs[0].left;
        audio_right = vecs[0].right;
        @(negedge clk);
        rst = 1'b0;

        run_frame("first_frame_zero", 32'h0, 32'h0, -1, '0);
        chk("first_mclk_rise", 32'(first_mclk), 32'd2);
        chk("first_sck_rise", 32'(first_sck), 32'd8);
        chk("first_lrck_rise", 32'(first_lrck), 32'd512);

        rise_mclk = 0; rise_sck = 0; rise_lrck = 0;
        high_mclk = 0; high_sck = 0; high_lrck = 0;
        for (int v = 0; v < 4; v++) begin
            if (v + 1 < 4) begin
                audio_left  = vecs[v+1].left;
                audio_right = vecs[v+1].right;
            end
            run_frame($sformatf("vec%0d", v), vecs[v].exp_l, vecs[v].exp_r, -1, '0);
        end
        chk("lrck_periods", 32'(rise_lrck), 32'd4);
        chk("sck_periods", 32'(rise_sck), 32'd256);
        chk("mclk_periods", 32'(rise_mclk), 32'd1024);
        chk("lrck_high", 32'(high_lrck), 32'd2048);
        chk("sck_high", 32'(high_sck), 32'd2048);
        chk("mclk_high", 32'(high_mclk), 32'd2048);

        // Capture isolation: left changes at cnt=100 of a B000 frame.
        audio_left  = 16'hB000;
        audio_right = 16'h5FFF;
        run_frame("iso_pre", vecs[3].exp_l, vecs[3].exp_r, -1, '0);
        run_frame("iso_cur", 32'h5800_0000, 32'h2FFF_8000, 100, 16'h1234);
        run_frame("iso_next", 32'h091A_0000, 32'h2FFF_8000, -1, '0);

        // Mid-frame reset at cnt=300.
        begin : mid_reset
            for (int i = 0; i < 1024; i++) begin
                if (m_cnt == 10'd300) break;
                tick();
            end
            chk("mid_reset_reached", 32'(m_cnt), 32'd300);
            rst = 1'b1;
            #1;
            chk_outputs_zero("mid_reset_now");
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk_outputs_zero("mid_reset_hold");
            end
            @(negedge clk);
            rst = 1'b0;
            m_cnt = '0;
            prev_sdin = 1'b0;
        end
        run_frame("post_reset_zero", 32'h0, 32'h0, -1, '0);
        run_frame("post_reset_data", 32'h091A_0000, 32'h2FFF_8000, -1, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
